sprite_renderer: RTL and testbench

Parametrised multi-sprite erase/redraw engine that feeds the 160x120, 3-bit-colour VGA framebuffer adapter, one pixel per clock. After every FRAME_DELAY idle cycles it walks sprites 0..NUM_SPR-1 in order. For each sprite it erases the rectangle at the previously drawn position in BG_COLOR, latches the new position and colour, and draws the new SPR_W x SPR_H rectangle. Pixels off-screen are clipped, unchanged sprites are skipped, and a hold input stalls scanning.

---
 rtl/sprite_renderer.sv | 163 ++++++++++++++++
 tb/tb_sprite_renderer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// Multi-sprite erase/redraw engine for a 160x120 3-bit framebuffer.
// One pixel per clock; unchanged sprites are skipped each sweep.
module sprite_renderer #(
  parameter int NUM_SPR     = 2,
  parameter int SPR_W       = 3,
  parameter int SPR_H       = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOR_W     = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int FRAME_DELAY = 5,
  parameter int BG_COLOR    = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_SPR-1:0]         spr_en,
  input  logic [NUM_SPR*X_W-1:0]     spr_x,
  input  logic [NUM_SPR*Y_W-1:0]     spr_y,
  input  logic [NUM_SPR*COLOR_W-1:0] spr_color,
  input  logic                       hold,
  output logic [X_W-1:0]             x_out,
  output logic [Y_W-1:0]             y_out,
  output logic [COLOR_W-1:0]         color_out,
  output logic                       plot,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int DW = $clog2(FRAME_DELAY + 1);
  localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [DW-1:0]      LAST_CNT = DW'(FRAME_DELAY - 1);
  localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_SPR - 1);
  localparam logic [CW-1:0]      LAST_COL = CW'(SPR_W - 1);
  localparam logic [RW-1:0]      LAST_ROW = RW'(SPR_H - 1);
  localparam logic [X_W:0]       SCR_W    = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]       SCR_H    = (Y_W + 1)'(SCREEN_H);
  localparam logic [COLOR_W-1:0] BG       = COLOR_W'(BG_COLOR);

  typedef enum logic [2:0] {
    S_WAIT, S_SEL, S_ERASE, S_LATCH, S_DRAW, S_NEXT
  } state_t;

  state_t             state;
  logic [DW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [NUM_SPR-1:0] drawn;
  logic [X_W-1:0]     old_x [NUM_SPR];
  logic [Y_W-1:0]     old_y [NUM_SPR];
  logic [COLOR_W-1:0] old_c [NUM_SPR];

  logic               cur_en;
  logic [X_W-1:0]     cur_x;
  logic [Y_W-1:0]     cur_y;
  logic [COLOR_W-1:0] cur_c;
  logic [X_W:0]       px;
  logic [Y_W:0]       py;
  logic               in_view;
  logic               last_px;
  logic               same;
  logic               go;

  always_comb begin
    cur_en  = spr_en[idx];
    cur_x   = spr_x[idx*X_W +: X_W];
    cur_y   = spr_y[idx*Y_W +: Y_W];
    cur_c   = spr_color[idx*COLOR_W +: COLOR_W];
    // One spare bit so sprites past the right/bottom edge clip, not wrap
    px      = {1'b0, old_x[idx]} + (X_W + 1)'(col);
    py      = {1'b0, old_y[idx]} + (Y_W + 1)'(row);
    in_view = (px < SCR_W) && (py < SCR_H);
    last_px = (col == LAST_COL) && (row == LAST_ROW);
    same    = (cur_x == old_x[idx]) && (cur_y == old_y[idx])
              && (cur_c == old_c[idx]);
    go      = (state == S_WAIT) && (cnt == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_WAIT;
      cnt        <= '0;
      idx        <= '0;
      col        <= '0;
      row        <= '0;
      drawn      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      color_out  <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_SPR; i++) begin
        old_x[i] <= '0;
        old_y[i] <= '0;
        old_c[i] <= '0;
      end
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      busy       <= (state != S_WAIT) || go;
      unique case (state)
        S_WAIT: begin
          if (go) begin
            cnt   <= '0;
            idx   <= '0;
            state <= S_SEL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SEL: begin
          if ((!cur_en && !drawn[idx]) || (cur_en && drawn[idx] && same))
            state <= S_NEXT;
          else if (drawn[idx])
            state <= S_ERASE;
          else
            state <= S_LATCH;
        end
        S_ERASE, S_DRAW: begin
          if (!hold) begin
            x_out     <= px[X_W-1:0];
            y_out     <= py[Y_W-1:0];
            color_out <= (state == S_ERASE) ? BG : old_c[idx];
            plot      <= in_view;
            if (last_px) begin
              col   <= '0;
              row   <= '0;
              state <= (state == S_ERASE) ? S_LATCH : S_NEXT;
            end else if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_LATCH: begin
          old_x[idx] <= cur_x;
          old_y[idx] <= cur_y;
          old_c[idx] <= cur_c;
          drawn[idx] <= cur_en;
          state      <= cur_en ? S_DRAW : S_NEXT;
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            frame_done <= 1'b1;
            state      <= S_WAIT;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_SEL;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: directed sweeps then random sweeps,
// each compared against a per-sweep rectangle list model.
module tb_sprite_renderer;

  localparam int N  = 2;
  localparam int W  = 3;
  localparam int H  = 4;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] spr_en = '0;
  logic [15:0]  spr_x = '0;
  logic [13:0]  spr_y = '0;
  logic [5:0]   spr_color = '0;
  logic         hold = 1'b0;
  logic [7:0]   x_out;
  logic [6:0]   y_out;
  logic [2:0]   color_out;
  logic         plot;
  logic         busy;
  logic         frame_done;

  sprite_renderer #(
    .NUM_SPR(N), .SPR_W(W), .SPR_H(H), .X_W(8), .Y_W(7),
    .COLOR_W(3), .SCREEN_W(160), .SCREEN_H(120),
    .FRAME_DELAY(FD), .BG_COLOR(0)
  ) dut (
    .clk(clk), .resetn(resetn), .spr_en(spr_en), .spr_x(spr_x),
    .spr_y(spr_y), .spr_color(spr_color), .hold(hold),
    .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .plot(plot), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit m_drawn [N];
  int m_x [N];
  int m_y [N];
  int m_c [N];
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int exp_cyc;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mk(input int x, input int y, input int c);
    logic [7:0] xx;
    logic [6:0] yy;
    logic [2:0] cc;
    xx = x[7:0];
    yy = y[6:0];
    cc = c[2:0];
    return {xx, yy, cc};
  endfunction

  task automatic rect(input int bx, input int by, input int c);
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++)
        if (bx + k < 160 && by + r < 120)
          exp_q.push_back(mk(bx + k, by + r, c));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_drawn[i] = 0;
      m_x[i] = 0;
      m_y[i] = 0;
      m_c[i] = 0;
    end
  endtask

  // Expected writes and busy cycles of one sweep from current inputs
  task automatic model_sweep();
    int nx, ny, nc;
    bit en;
    exp_q.delete();
    exp_cyc = 1;
    for (int i = 0; i < N; i++) begin
      en = spr_en[i];
      nx = int'(spr_x[i*8 +: 8]);
      ny = int'(spr_y[i*7 +: 7]);
      nc = int'(spr_color[i*3 +: 3]);
      exp_cyc += 2;
      if (!en && !m_drawn[i]) continue;
      if (en && m_drawn[i] && nx == m_x[i] && ny == m_y[i] && nc == m_c[i])
        continue;
      if (m_drawn[i]) begin
        exp_cyc += W * H;
        rect(m_x[i], m_y[i], 0);
      end
      exp_cyc += 1;
      m_x[i] = nx;
      m_y[i] = ny;
      m_c[i] = nc;
      m_drawn[i] = en;
      if (en) begin
        exp_cyc += W * H;
        rect(nx, ny, nc);
      end
    end
  endtask

  task automatic run_sweep(input string tag, input int hold_at,
                           input int hold_len, input int rst_at);
    int bc, hcnt, n;
    bit to;
    model_sweep();
    got_q.delete();
    bc = 0;
    hcnt = 0;
    to = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) hold = 1'b0;
      end
      if (plot) got_q.push_back({x_out, y_out, color_out});
      if (busy) bc++;
      if (plot && hold_at >= 0 && got_q.size() == hold_at) begin
        hold = 1'b1;
        hcnt = hold_len;
      end
      if (plot && rst_at >= 0 && got_q.size() == rst_at) begin
        resetn = 1'b0;
        @(negedge clk);
        check({tag, " rst x"}, 32'(x_out), 0);
        check({tag, " rst y"}, 32'(y_out), 0);
        check({tag, " rst c"}, 32'(color_out), 0);
        check({tag, " rst plot"}, 32'(plot), 0);
        check({tag, " rst busy"}, 32'(busy), 0);
        check({tag, " rst fd"}, 32'(frame_done), 0);
        resetn = 1'b1;
        model_reset();
        return;
      end
      if (frame_done) begin
        to = 0;
        break;
      end
    end
    check({tag, " timeout"}, 32'(to), 0);
    check({tag, " nplots"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s pix%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " busy"}, bc, exp_cyc + ((hold_at >= 0) ? hold_len : 0));
    @(negedge clk);
    check({tag, " fd pulse"}, 32'(frame_done), 0);
  endtask

  task automatic set_spr(input int i, input bit en, input int x,
                         input int y, input int c);
    spr_en[i] = en;
    spr_x[i*8 +: 8] = 8'(x);
    spr_y[i*7 +: 7] = 7'(y);
    spr_color[i*3 +: 3] = 3'(c);
  endtask

  initial begin
    model_reset();
    set_spr(0, 1, 3, 3, 5);
    set_spr(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset x", 32'(x_out), 0);
    check("reset y", 32'(y_out), 0);
    check("reset c", 32'(color_out), 0);
    check("reset plot", 32'(plot), 0);
    check("reset busy", 32'(busy), 0);
    check("reset fd", 32'(frame_done), 0);
    resetn = 1'b1;

    run_sweep("first", -1, 0, -1);
    check("first p0", 32'(got_q[0]), 32'(mk(3, 3, 5)));
    check("first p3", 32'(got_q[3]), 32'(mk(3, 4, 5)));
    set_spr(0, 1, 4, 3, 5);
    run_sweep("move", -1, 0, -1);
    run_sweep("same", -1, 0, -1);
    set_spr(0, 1, 158, 118, 6);
    run_sweep("clip", -1, 0, -1);
    set_spr(1, 1, 20, 30, 2);
    run_sweep("s1on", -1, 0, -1);
    set_spr(1, 0, 20, 30, 2);
    run_sweep("s1off", -1, 0, -1);
    run_sweep("idle", -1, 0, -1);
    check("idle plots", got_q.size(), 0);
    set_spr(0, 1, 3, 3, 5);
    run_sweep("hold", 4 + 6, 5, -1);
    set_spr(0, 1, 50, 50, 3);
    run_sweep("rst", -1, 0, 12 + 3);
    run_sweep("postrst", -1, 0, -1);

    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: ;
          1: set_spr(i, 1, $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 7));
          2: set_spr(i, 1, $urandom_range(150, 165), $urandom_range(110, 127),
                     $urandom_range(0, 7));
          default: spr_en[i] = ~spr_en[i];
        endcase
      end
      run_sweep($sformatf("rnd%0d", s), -1, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
